fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//   Sequences instruction fetch between the PC register and a handshaked instruction memory.
//   Owns the fetch PC and issues one request at a time. Absorbs decode stalls and applies
//   execute-stage redirects (branch/jump), discarding stale responses. Drives the IF/ID
//   pipeline register (PC_D, instruction_D, if_valid_D) feeding the decode stage.
// PARAMETERS
//   RESET_PC  64'h0  fetch address loaded on reset
//   PC_W      64     PC / address width
//   INSTR_W   32     instruction width
// PORTS
//   clk            in   1      clock, rising edge
//   reset          in   1      asynchronous, active-low reset
//   imem_req_valid out  1      fetch request valid
//   imem_req_ready in   1      memory accepts request
//   imem_req_addr  out  PC_W   fetch address
//   imem_rsp_valid in   1      instruction returned
//   imem_rsp_ready out  1      controller accepts response
//   imem_rsp_data  in   INSTR_W returned instruction
//   PCSrc_E        in   1      redirect request from execute
//   PC_Target_E    in   PC_W   redirect target
//   stall_D        in   1      decode cannot accept; hold IF/ID register
//   if_valid_D     out  1      PC_D/instruction_D hold a valid instruction
//   PC_D           out  PC_W   PC of instruction in IF/ID
//   instruction_D  out  INSTR_W instruction in IF/ID
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, pc_r=RESET_PC, all outputs 0.
//   FSM states IDLE, REQ, WAIT, DRAIN. At most one request outstanding.
//   IDLE: outputs quiet; next cycle -> REQ.
//   REQ: imem_req_valid=1, addr=pc_r. Accept (valid&ready) -> WAIT.
//     PCSrc_E: pc_r<=PC_Target_E, stay REQ. Addr changes only on redirect, or if accepted same cycle -> DRAIN.
//   WAIT: imem_rsp_ready = !(if_valid_D && stall_D).
//     Accept rsp, no redirect: PC_D<=pc_r, instruction_D<=data, if_valid_D<=1, pc_r<=pc_r+4, -> REQ.
//     Redirect + rsp accepted same cycle: drop rsp, pc_r<=target, -> REQ.
//     Redirect, no rsp: pc_r<=target, -> DRAIN.
//   DRAIN: imem_rsp_ready=1. Rsp: discard -> REQ. Further redirects update pc_r only.
//   IF/ID register: redirect clears if_valid_D next cycle (beats stall_D).
//     Else stall_D && if_valid_D holds all three outputs.
//     Else if_valid_D<=0 unless a response is loaded.
//   PC arithmetic: modulo 2^PC_W; +4 wraps silently at top of address space.
//   Latency: req accepted cycle N, rsp at N+1 -> if_valid_D at N+2. Peak 1 instr / 2 cycles.
//   Reset mid-request: aborts immediately. Memory must drop any in-flight response on reset.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: adds outputs
//     perf_fetched    [63:0]  responses delivered to IF/ID
//     perf_flushes    [31:0]  redirect cycles
//     perf_stall_cyc  [31:0]  cycles with if_valid_D && stall_D
//   Counters reset to 0, wrap silently. Macro undefined: ports and logic absent; core unchanged.
// STRUCTURE
//   Package fetch_pkg: FSM state encoding (IDLE/REQ/WAIT/DRAIN), PC_INC=4, NOP=32'h0000_0013.
//   Sub-module fetch_perf_counters holds counters under FETCH_PERF_CNT_EN; rest is flat.
// TESTING
//   1 Reset release, RESET_PC=0, ready=1, rsp next cycle -> addrs 0,4,8; PC_D 0,4,8 each valid 1 cycle.
//   2 stall_D=1 for 3 cycles with if_valid_D=1 -> outputs frozen, rsp_ready=0, no new req.
//   3 PCSrc_E=1, target 0x100, during WAIT with no rsp -> DRAIN; stale rsp dropped; next addr 0x100.
//   4 Redirect same cycle as rsp_valid (target 0x200) -> if_valid_D=0 next cycle, next addr 0x200.
//   5 req_ready=0 for 4 cycles -> req_valid stays 1, addr stable; redirect mid-wait changes addr.
//   6 PC=0xFFFF_FFFF_FFFF_FFFC fetched -> next addr wraps to 0; async reset mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller:
// FSM state encoding, PC increment and the NOP encoding used
// to scrub the IF/ID instruction field on a flush.
// Optional feature macro: FETCH_PERF_CNT_EN (see fetch_controller.sv).
package fetch_pkg;

    // Fetch sequencer states; exported on the debug state port
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // post-reset bubble, bus quiet
        ST_REQ   = 2'd1,  // request presented, waiting for acceptance
        ST_WAIT  = 2'd2,  // request accepted, waiting for the response
        ST_DRAIN = 2'd3   // flushed request in flight, response will be dropped
    } fetch_state_t;

    // Byte distance between consecutive fixed-width instructions
    localparam int unsigned PC_INC = 4;

    // addi x0, x0, 0 -- harmless filler loaded into IF/ID when it is flushed
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage : fetch_pkg

// File: rtl/fetch_perf_counters.sv
// Free-running fetch performance counters. Present only when the
// FETCH_PERF_CNT_EN macro is defined; all counters clear on reset
// and wrap silently.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_fetched,   // response loaded into IF/ID this cycle
    input  logic        i_flush,     // redirect applied this cycle
    input  logic        i_stall,     // IF/ID valid and held by decode this cycle
    output logic [63:0] o_fetched,
    output logic [31:0] o_flushes,
    output logic [31:0] o_stall_cyc
);

    logic [63:0] r_fetched;
    logic [31:0] r_flushes;
    logic [31:0] r_stall_cyc;

    // Count qualifying events; each counter wraps at its own width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetched   <= '0;
            r_flushes   <= '0;
            r_stall_cyc <= '0;
        end else begin
            if (i_fetched) begin
                r_fetched <= r_fetched + 64'd1;
            end
            if (i_flush) begin
                r_flushes <= r_flushes + 32'd1;
            end
            if (i_stall) begin
                r_stall_cyc <= r_stall_cyc + 32'd1;
            end
        end
    end

    assign o_fetched   = r_fetched;
    assign o_flushes   = r_flushes;
    assign o_stall_cyc = r_stall_cyc;

endmodule : fetch_perf_counters
`endif

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the fetch PC, issues one
// instruction-memory request at a time, applies execute-stage
// redirects (dropping stale responses) and drives the IF/ID register.
//
// Handshakes: a transfer happens on a rising clock edge where both
// valid and ready are high. The request side holds valid and address
// steady until accepted (the address changes only on a redirect); the
// response side accepts whenever rsp_ready is high.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched,
// perf_flushes and perf_stall_cyc outputs; undefined, they are absent.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,          // asynchronous, active low
    // instruction memory request channel
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    // instruction memory response channel
    input  logic               imem_rsp_valid,
    output logic               imem_rsp_ready,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    // execute-stage redirect
    input  logic               PCSrc_E,
    input  logic [PC_W-1:0]    PC_Target_E,
    // decode back-pressure
    input  logic               stall_D,
    // IF/ID pipeline register
    output logic               if_valid_D,
    output logic [PC_W-1:0]    PC_D,
    output logic [INSTR_W-1:0] instruction_D,
    // current sequencer state, for observation only
    output fetch_state_t       o_dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]        perf_fetched,
    output logic [31:0]        perf_flushes,
    output logic [31:0]        perf_stall_cyc
`endif
);

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_if_valid;
    logic [PC_W-1:0]    r_pc_d;
    logic [INSTR_W-1:0] r_instr_d;

    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_rsp_ready;
    logic               w_rsp_fire;
    logic               w_hold;
    logic               w_load;
    logic [PC_W-1:0]    w_pc_next_seq;

    // Decode is holding a valid instruction: IF/ID must not change
    assign w_hold = r_if_valid && stall_D;

    // Request is a pure function of state so it never glitches on inputs
    assign w_req_valid = (r_state == ST_REQ);
    assign w_req_fire  = w_req_valid && imem_req_ready;

    // Response acceptance: blocked in WAIT only while IF/ID is held;
    // always open in DRAIN so the stale response is absorbed promptly
    always_comb begin
        w_rsp_ready = 1'b0;
        case (r_state)
            ST_WAIT:  w_rsp_ready = !w_hold;
            ST_DRAIN: w_rsp_ready = 1'b1;
            default:  w_rsp_ready = 1'b0;
        endcase
    end

    assign w_rsp_fire = w_rsp_ready && imem_rsp_valid;

    // A response reaches IF/ID only if it belongs to the current PC stream
    assign w_load = (r_state == ST_WAIT) && w_rsp_fire && !PCSrc_E;

    // Sequential next PC; wraps modulo 2^PC_W
    assign w_pc_next_seq = r_pc + PC_W'(PC_INC);

    // Fetch sequencer: state and fetch PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (PCSrc_E) begin
                        r_pc <= PC_Target_E;
                    end
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (PCSrc_E) begin
                        r_pc <= PC_Target_E;
                        // accepted request now fetches a dead address
                        if (w_req_fire) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (w_req_fire) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (PCSrc_E) begin
                        r_pc <= PC_Target_E;
                        // response consumed this cycle is dropped; otherwise
                        // its later arrival has to be drained
                        r_state <= w_rsp_fire ? ST_REQ : ST_DRAIN;
                    end else if (w_rsp_fire) begin
                        r_pc    <= w_pc_next_seq;
                        r_state <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (PCSrc_E) begin
                        r_pc <= PC_Target_E;
                    end
                    if (w_rsp_fire) begin
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // IF/ID register: redirect flush beats stall, stall beats load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_valid <= 1'b0;
            r_pc_d     <= '0;
            r_instr_d  <= '0;
        end else if (PCSrc_E) begin
            r_if_valid <= 1'b0;
            r_instr_d  <= INSTR_W'(NOP);
        end else if (w_hold) begin
            r_if_valid <= r_if_valid;
        end else if (w_load) begin
            r_if_valid <= 1'b1;
            r_pc_d     <= r_pc;
            r_instr_d  <= imem_rsp_data;
        end else begin
            r_if_valid <= 1'b0;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = w_req_valid ? r_pc : '0;
    assign imem_rsp_ready = w_rsp_ready;
    assign if_valid_D     = r_if_valid;
    assign PC_D           = r_pc_d;
    assign instruction_D  = r_instr_d;
    assign o_dbg_state    = r_state;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst_n       (reset),
        .i_fetched   (w_load),
        .i_flush     (PCSrc_E),
        .i_stall     (w_hold),
        .o_fetched   (perf_fetched),
        .o_flushes   (perf_flushes),
        .o_stall_cyc (perf_stall_cyc)
    );
`endif

endmodule : fetch_controller

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller. A behavioural instruction
// memory answers each accepted request one cycle later with a
// data word derived from the address; expected IF/ID contents are
// queued per scenario and checked whenever a new instruction lands.
module tb_fetch_controller;
    import fetch_pkg::*;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic               imem_rsp_ready;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               PCSrc_E;
    logic [PC_W-1:0]    PC_Target_E;
    logic               stall_D;
    logic               if_valid_D;
    logic [PC_W-1:0]    PC_D;
    logic [INSTR_W-1:0] instruction_D;
    fetch_state_t       dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0]        perf_fetched;
    logic [31:0]        perf_flushes;
    logic [31:0]        perf_stall_cyc;
`endif

    fetch_controller #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .PCSrc_E        (PCSrc_E),
        .PC_Target_E    (PC_Target_E),
        .stall_D        (stall_D),
        .if_valid_D     (if_valid_D),
        .PC_D           (PC_D),
        .instruction_D  (instruction_D),
        .o_dbg_state    (dbg_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushes   (perf_flushes),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [PC_W+INSTR_W-1:0] exp_q[$];
    bit new_del;
    bit mem_hold;

    function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
        return a[31:0] ^ 32'hC0DE_5A5A;
    endfunction

    function automatic void push_exp(input logic [PC_W-1:0] a);
        exp_q.push_back({a, instr_of(a)});
    endfunction

    // ---------------- instruction memory model ----------------
    bit              m_req_fire;
    bit              m_rsp_fire;
    bit              m_pend;
    logic [PC_W-1:0] m_addr_s;
    logic [PC_W-1:0] m_pend_addr;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        m_pend         = 1'b0;
        m_pend_addr    = '0;
        forever begin
            @(posedge clk);
            m_req_fire = imem_req_valid && imem_req_ready;
            m_rsp_fire = imem_rsp_valid && imem_rsp_ready;
            m_addr_s   = imem_req_addr;
            #1;
            if (!rst_n) begin
                m_pend         = 1'b0;
                imem_rsp_valid = 1'b0;
            end else begin
                if (m_rsp_fire) imem_rsp_valid = 1'b0;
                if (m_req_fire) begin
                    m_pend      = 1'b1;
                    m_pend_addr = m_addr_s;
                end
                if (m_pend && !imem_rsp_valid && !mem_hold) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = instr_of(m_pend_addr);
                    m_pend         = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance one cycle and score any newly loaded IF/ID entry
    task automatic tick();
        bit pv, ps;
        logic [PC_W+INSTR_W-1:0] e;
        pv = if_valid_D;
        ps = stall_D;
        new_del = 1'b0;
        @(posedge clk);
        #2;
        if (rst_n && if_valid_D && !(pv && ps)) begin
            new_del = 1'b1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL deliver: got unexpected PC_D=%h instr=%h, required none", PC_D, instruction_D);
            end else begin
                e = exp_q.pop_front();
                if ({PC_D, instruction_D} !== e) begin
                    miscompares++;
                    $display("FAIL deliver: got PC_D=%h instr=%h, required PC_D=%h instr=%h",
                             PC_D, instruction_D, e[PC_W+INSTR_W-1:INSTR_W], e[INSTR_W-1:0]);
                end
            end
        end
    endtask

    task automatic wait_deliver(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (new_del) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: no delivery within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        PCSrc_E        = 1'b0;
        PC_Target_E    = '0;
        stall_D        = 1'b0;
        imem_req_ready = 1'b1;
        mem_hold       = 1'b0;
        tick();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d expected deliveries never seen, required 0", exp_q.size());
        end
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n          = 1'b0;
        PCSrc_E        = 1'b0;
        PC_Target_E    = '0;
        stall_D        = 1'b0;
        imem_req_ready = 1'b1;
        mem_hold       = 1'b0;
        tick();
        tick();
        vectors++;
        if ({imem_req_valid, imem_req_addr, imem_rsp_ready, if_valid_D, PC_D, instruction_D} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req_v=%b addr=%h rsp_r=%b v=%b pc=%h ins=%h, required all 0",
                     imem_req_valid, imem_req_addr, imem_rsp_ready, if_valid_D, PC_D, instruction_D);
        end
        vectors++;
        if (dbg_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (!(imem_req_valid === 1'b1 && imem_req_addr === 64'h0)) begin
            miscompares++;
            $display("FAIL reset_first_req: got valid=%b addr=%h, required valid=1 addr=0", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        logic [PC_W-1:0] a;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a = PC_W'(4 * k);
            push_exp(a);
            wait_deliver("seq_deliver", 8);
            vectors++;
            if (!(imem_req_valid === 1'b1 && imem_req_addr === a + 64'd4)) begin
                miscompares++;
                $display("FAIL seq_next_addr: got valid=%b addr=%h, required valid=1 addr=%h",
                         imem_req_valid, imem_req_addr, a + 64'd4);
            end
            tick();
            vectors++;
            if (if_valid_D !== 1'b0) begin
                miscompares++;
                $display("FAIL seq_valid_pulse: got if_valid_D=%b, required 0", if_valid_D);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        push_exp(64'h0);
        wait_deliver("stall_first", 8);
        stall_D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (!(if_valid_D === 1'b1 && PC_D === 64'h0 && instruction_D === instr_of(64'h0))) begin
                miscompares++;
                $display("FAIL stall_hold: got v=%b pc=%h ins=%h, required v=1 pc=0 ins=%h",
                         if_valid_D, PC_D, instruction_D, instr_of(64'h0));
            end
            vectors++;
            if (!(imem_req_valid === 1'b0 && imem_rsp_ready === 1'b0)) begin
                miscompares++;
                $display("FAIL stall_bus: got req_v=%b rsp_r=%b, required 0 0", imem_req_valid, imem_rsp_ready);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (perf_stall_cyc !== 32'd3) begin
            miscompares++;
            $display("FAIL perf_stall: got %0d, required 3", perf_stall_cyc);
        end
`endif
        stall_D = 1'b0;
        push_exp(64'h4);
        wait_deliver("stall_release", 4);
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (perf_fetched !== 64'd2) begin
            miscompares++;
            $display("FAIL perf_fetched: got %0d, required 2", perf_fetched);
        end
`endif
    endtask

    task automatic test_redirect_wait();
        bit seen;
        do_reset();
        mem_hold = 1'b1;
        tick();
        tick();
        vectors++;
        if (dbg_state !== ST_WAIT) begin
            miscompares++;
            $display("FAIL rw_wait: got state %0d, required %0d", dbg_state, ST_WAIT);
        end
        PCSrc_E     = 1'b1;
        PC_Target_E = 64'h100;
        tick();
        PCSrc_E = 1'b0;
        vectors++;
        if (!(dbg_state === ST_DRAIN && imem_req_valid === 1'b0 && imem_rsp_ready === 1'b1 && if_valid_D === 1'b0)) begin
            miscompares++;
            $display("FAIL rw_drain: got state=%0d req_v=%b rsp_r=%b v=%b, required state=%0d 0 1 0",
                     dbg_state, imem_req_valid, imem_rsp_ready, if_valid_D, ST_DRAIN);
        end
        mem_hold = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (imem_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!(seen && imem_req_addr === 64'h100)) begin
            miscompares++;
            $display("FAIL rw_new_addr: got seen=%b addr=%h, required seen=1 addr=100", seen, imem_req_addr);
        end
        push_exp(64'h100);
        wait_deliver("rw_deliver", 8);
    endtask

    task automatic test_redirect_with_rsp();
        do_reset();
        tick();
        tick();
        PCSrc_E     = 1'b1;
        PC_Target_E = 64'h200;
        tick();
        PCSrc_E = 1'b0;
        vectors++;
        if (!(if_valid_D === 1'b0 && dbg_state === ST_REQ && imem_req_addr === 64'h200)) begin
            miscompares++;
            $display("FAIL rr_drop: got v=%b state=%0d addr=%h, required v=0 state=%0d addr=200",
                     if_valid_D, dbg_state, imem_req_addr, ST_REQ);
        end
        push_exp(64'h200);
        wait_deliver("rr_deliver", 8);
        // a redirect must flush IF/ID even while decode is stalling
        stall_D = 1'b1;
        tick();
        PCSrc_E     = 1'b1;
        PC_Target_E = 64'h300;
        tick();
        PCSrc_E = 1'b0;
        stall_D = 1'b0;
        vectors++;
        if (!(if_valid_D === 1'b0 && dbg_state === ST_DRAIN)) begin
            miscompares++;
            $display("FAIL rr_flush_over_stall: got v=%b state=%0d, required v=0 state=%0d",
                     if_valid_D, dbg_state, ST_DRAIN);
        end
        push_exp(64'h300);
        wait_deliver("rr_after_flush", 8);
    endtask

    task automatic test_req_backpressure();
        do_reset();
        imem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (!(imem_req_valid === 1'b1 && imem_req_addr === 64'h0)) begin
                miscompares++;
                $display("FAIL bp_hold: got valid=%b addr=%h, required 1 0", imem_req_valid, imem_req_addr);
            end
        end
        PCSrc_E     = 1'b1;
        PC_Target_E = 64'h400;
        tick();
        PCSrc_E = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (!(imem_req_valid === 1'b1 && imem_req_addr === 64'h400 && dbg_state === ST_REQ)) begin
                miscompares++;
                $display("FAIL bp_redirect: got valid=%b addr=%h state=%0d, required 1 400 %0d",
                         imem_req_valid, imem_req_addr, dbg_state, ST_REQ);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        push_exp(64'h400);
        wait_deliver("bp_deliver", 8);
        // redirect in the same cycle the request is accepted
        PCSrc_E     = 1'b1;
        PC_Target_E = 64'h500;
        tick();
        PCSrc_E = 1'b0;
        vectors++;
        if (dbg_state !== ST_DRAIN) begin
            miscompares++;
            $display("FAIL bp_accept_redirect: got state %0d, required %0d", dbg_state, ST_DRAIN);
        end
        push_exp(64'h500);
        wait_deliver("bp_after_drain", 8);
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        imem_req_ready = 1'b0;
        tick();
        PCSrc_E     = 1'b1;
        PC_Target_E = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        PCSrc_E        = 1'b0;
        imem_req_ready = 1'b1;
        push_exp(64'hFFFF_FFFF_FFFF_FFFC);
        wait_deliver("wrap_deliver", 8);
        vectors++;
        if (!(imem_req_valid === 1'b1 && imem_req_addr === 64'h0)) begin
            miscompares++;
            $display("FAIL wrap_addr: got valid=%b addr=%h, required 1 0", imem_req_valid, imem_req_addr);
        end
        tick();
        vectors++;
        if (dbg_state !== ST_WAIT) begin
            miscompares++;
            $display("FAIL wrap_wait: got state %0d, required %0d", dbg_state, ST_WAIT);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({imem_req_valid, imem_req_addr, imem_rsp_ready, if_valid_D, PC_D, instruction_D} !== '0
            || dbg_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL async_reset: got req_v=%b addr=%h rsp_r=%b v=%b pc=%h ins=%h state=%0d, required all 0",
                     imem_req_valid, imem_req_addr, imem_rsp_ready, if_valid_D, PC_D, instruction_D, dbg_state);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (!(imem_req_valid === 1'b1 && imem_req_addr === 64'h0)) begin
            miscompares++;
            $display("FAIL async_restart: got valid=%b addr=%h, required 1 0", imem_req_valid, imem_req_addr);
        end
        push_exp(64'h0);
        wait_deliver("async_deliver", 8);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_with_rsp();
        test_req_backpressure();
        test_wrap_and_async_reset();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_controller
